shift_sequencer: RTL and testbench

Command-driven sequencer for the team's 4-bit bidirectional shift register. It accepts a serial-load command (data word, bit count, direction) over a valid/ready handshake. It then drives the register's direction and serial-input pins one bit per clock, and returns a snapshot of the register's parallel output over a second valid/ready handshake. The sequencer sits between a command master and the shift register. The register has no enable and shifts on every clock, so the sequencer owns its serial inputs continuously.

---
 rtl/shift_sequencer.sv | 120 ++++++++++++
 tb/tb_shift_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer
//
// Turns a serial-load command into one bit per clock on the serial inputs of
// the 4-bit bidirectional shift register. When the load is done it returns a
// snapshot of the register's parallel output. The register shifts on every
// clock and has no enable, so this block drives its serial inputs all the
// time. Whenever no command bit is being presented, both serial inputs carry
// FILL.
//
// Ports
//   clk, rst_n        clock; synchronous active-low reset
//   cmd_valid/ready   command handshake (ready only in IDLE)
//   cmd_dir           1 = load through si_left, 0 = load through si_right
//   cmd_len           bits to shift; 0 = snapshot only; clamped to DW
//   cmd_data          payload, sent LSB first
//   sr_direction      register direction pin (registered)
//   sr_si_left/right  register serial inputs (registered)
//   sr_out            register parallel output
//   rsp_valid/ready   snapshot handshake
//   rsp_data          sr_out captured after exactly len_eff shifts
//   busy              high whenever not IDLE
module shift_sequencer #(
  parameter int   DW   = 8,
  parameter int   LW   = 4,
  parameter int   SRW  = 4,
  parameter logic FILL = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_dir,
  input  logic [LW-1:0]  cmd_len,
  input  logic [DW-1:0]  cmd_data,
  output logic           sr_direction,
  output logic           sr_si_left,
  output logic           sr_si_right,
  input  logic [SRW-1:0] sr_out,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [SRW-1:0] rsp_data,
  output logic           busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_CAPT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    state;
  logic [DW-1:0] data_q;   // remaining payload; bit 0 is the next bit to present
  logic [LW-1:0] len_q;
  logic [LW-1:0] idx;
  logic [LW-1:0] len_eff;
  logic          last_bit;

  assign len_eff   = (cmd_len > LW'(DW)) ? LW'(DW) : cmd_len;
  assign last_bit  = (idx + LW'(1)) == len_q;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      data_q       <= '0;
      len_q        <= '0;
      idx          <= '0;
      sr_direction <= 1'b0;
      sr_si_left   <= FILL;
      sr_si_right  <= FILL;
      rsp_data     <= '0;
    end else begin
      // Serial inputs fall back to FILL unless a command bit is loaded below.
      sr_si_left  <= FILL;
      sr_si_right <= FILL;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            // Bit 0 goes onto the pins at the accept edge, so the register
            // takes it in on the very next edge.
            data_q       <= cmd_data >> 1;
            len_q        <= len_eff;
            idx          <= '0;
            sr_direction <= cmd_dir;
            if (len_eff != '0) begin
              state <= S_SHIFT;
              if (cmd_dir) sr_si_left  <= cmd_data[0];
              else         sr_si_right <= cmd_data[0];
            end else begin
              state <= S_CAPT;
            end
          end
        end
        S_SHIFT: begin
          idx <= idx + LW'(1);
          // sr_direction holds the latched dir for the whole command.
          if (last_bit) begin
            state <= S_CAPT;
          end else begin
            data_q <= data_q >> 1;
            if (sr_direction) sr_si_left  <= data_q[0];
            else              sr_si_right <= data_q[0];
          end
        end
        S_CAPT: begin
          // sr_out here reflects exactly len_eff command shifts.
          rsp_data <= sr_out;
          state    <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;
  localparam int   DW   = 8;
  localparam int   LW   = 4;
  localparam int   SRW  = 4;
  localparam logic FILL = 1'b0;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_dir = 1'b0;
  logic [LW-1:0]  cmd_len = '0;
  logic [DW-1:0]  cmd_data = '0;
  logic           rsp_ready = 1'b1;
  logic           cmd_ready, sr_direction, sr_si_left, sr_si_right, rsp_valid, busy;
  logic [SRW-1:0] sr_out, rsp_data;
  logic [SRW-1:0] sr_q = '0;

  int cyc = 0, checks = 0, errors = 0, acc_cnt = 0, hs_cnt = 0, pushed = 0;

  typedef struct { logic [SRW-1:0] data; int due; } exp_t;
  exp_t sb[$];

  shift_sequencer #(.DW(DW), .LW(LW), .SRW(SRW), .FILL(FILL)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .sr_direction(sr_direction), .sr_si_left(sr_si_left), .sr_si_right(sr_si_right),
    .sr_out(sr_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shift register: dir=1 shifts left taking si_left at bit 0,
  // dir=0 shifts right taking si_right at bit 3. Shifts every clock.
  always @(posedge clk)
    sr_q <= sr_direction ? {sr_q[2:0], sr_si_left} : {sr_si_right, sr_q[3:1]};
  assign sr_out = sr_q;

  always @(posedge clk) begin
    if (rst_n && cmd_valid && cmd_ready) acc_cnt++;
    if (rst_n && rsp_valid && rsp_ready) hs_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard when a response appears, then checks that
  // rsp_data holds for as long as rsp_valid stays high.
  logic           prev_v = 1'b0;
  logic [SRW-1:0] held = '0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (rsp_valid === 1'b1) begin
      if (!prev_v) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_latency", cyc, e.due);
        end
        held = rsp_data;
      end else begin
        chk("rsp_hold", rsp_data, held);
      end
    end
    prev_v = (rsp_valid === 1'b1);
  end

  // Called at a negedge; returns at a negedge. e0 is the accept edge number.
  task automatic send(input logic d, input logic [LW-1:0] l, input logic [DW-1:0] dat,
                      input logic [SRW-1:0] xp, input bit want_rsp, output int e0);
    int leff, n;
    leff = (int'(l) > DW) ? DW : int'(l);
    cmd_dir = d; cmd_len = l; cmd_data = dat; cmd_valid = 1'b1;
    n = 0; e0 = -1;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk); n++;
    end
    if (cmd_ready !== 1'b1) begin
      chk("accept_timeout", n, 0);
      cmd_valid = 1'b0;
      return;
    end
    e0 = cyc + 1;
    if (want_rsp) begin
      sb.push_back('{xp, e0 + leff + 1});
      pushed++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    if (!want_rsp) return;
    for (int k = 0; k <= leff; k++) begin
      if (k > 0) @(negedge clk);
      chk("sr_direction", sr_direction, d);
      chk("si_left",  sr_si_left,  (d && k < leff)  ? dat[k] : FILL);
      chk("si_right", sr_si_right, (!d && k < leff) ? dat[k] : FILL);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e_a, e_b, e_c, c_rel, n;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_dir", sr_direction, 0);
    chk("rst_si_left", sr_si_left, FILL);
    chk("rst_si_right", sr_si_right, FILL);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset during the third SHIFT cycle of an 8-bit left load of 1s.
    send(1'b1, 4'd8, 8'hFF, 4'h0, 1'b0, e_a);
    repeat (2) @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_si_left", sr_si_left, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_busy", busy, 0);
    chk("mr_cmd_ready", cmd_ready, 1);
    chk("mr_rsp_valid", rsp_valid, 0);
    chk("mr_dir", sr_direction, 0);
    chk("mr_si_left", sr_si_left, FILL);
    chk("mr_si_right", sr_si_right, FILL);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

    send(1'b1, 4'd8,  8'hA5, 4'h5, 1'b1, e_a);   // left load
    send(1'b0, 4'd4,  8'h0B, 4'hB, 1'b1, e_a);   // right load
    send(1'b1, 4'd0,  8'hFF, 4'h1, 1'b1, e_a);   // snapshot only
    send(1'b1, 4'd15, 8'hA5, 4'h5, 1'b1, e_a);   // clamped to 8

    // Backpressure: hold the response for 20 cycles with a second command waiting.
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("bp_idle", cmd_ready, 1);
    rsp_ready = 1'b0;
    send(1'b0, 4'd4, 8'h3C, 4'hC, 1'b1, e_a);
    c_rel = 0;
    fork
      send(1'b1, 4'd4, 8'h09, 4'h9, 1'b1, e_b);
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          chk("bp_cmd_ready", cmd_ready, 0);
          chk("bp_busy", busy, 1);
        end
        rsp_ready = 1'b1;
        c_rel = cyc;
      end
    join
    chk("bp_accept_edge", e_b, c_rel + 2);

    // Back-to-back len=2 commands with rsp_ready high.
    send(1'b1, 4'd2, 8'h01, 4'h2, 1'b1, e_a);
    send(1'b1, 4'd2, 8'h02, 4'h1, 1'b1, e_b);
    send(1'b1, 4'd2, 8'h03, 4'h3, 1'b1, e_c);
    chk("b2b_gap1", e_b - e_a, 5);
    chk("b2b_gap2", e_c - e_b, 5);

    repeat (10) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("accept_count", acc_cnt, 10);
    chk("rsp_count", hs_cnt, pushed);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
